// File: rtl/hft_pkg.sv
// Shared trading-path types: fill side, inventory tracker FSM states, default widths.
package hft_pkg;

   localparam int unsigned INV_W_DEFAULT = 64;

   typedef enum logic {
      BUY  = 1'b0,
      SELL = 1'b1
   } side_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ZERO  = 2'd2,
      HOLD  = 2'd3
   } inv_state_t;

endpackage

// File: rtl/inventory_tracker_if.sv
// Fill-event valid/ready channel from the exchange gateway into the inventory tracker.
interface inventory_tracker_if #(
   parameter int unsigned QTY_W = 32
);
   logic                i_fill_valid;
   logic                o_fill_ready;
   hft_pkg::side_t      i_fill_side;
   logic [QTY_W-1:0]    i_fill_qty;

   modport master (output i_fill_valid, i_fill_side, i_fill_qty, input o_fill_ready);
   modport slave  (input i_fill_valid, i_fill_side, i_fill_qty, output o_fill_ready);
endinterface

// File: rtl/inventory_tracker_sat_add_s.sv
// Signed saturating adder: two (W+1)-bit operands clamped into a W-bit signed result.
module sat_add_s #(
   parameter int unsigned W = 64
) (
   input  logic signed [W:0]   a,
   input  logic signed [W:0]   b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);
   logic [W+1:0] full;

   // One guard bit above the operands so the raw sum itself can never wrap
   assign full = {a[W], a} + {b[W], b};
   assign ovf  = !((full[W+1:W-1] == 3'b000) || (full[W+1:W-1] == 3'b111));

   always_comb begin
      sum = full[W-1:0];
      if (ovf) begin
         sum = full[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
endmodule

// File: rtl/inventory_tracker.sv
// Signed net-position tracker fed by exchange fills, with limit flags and a flatten sequence.
// Optional per-side volume counters when INV_TRACKER_STATS_EN is defined.
module inventory_tracker
   import hft_pkg::*;
#(
   parameter int unsigned QTY_W     = 32,
   parameter int unsigned INV_W     = INV_W_DEFAULT,
   parameter int unsigned POS_LIMIT = 10000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   inventory_tracker_if.slave      fill,
   input  logic                    i_flatten,
   output logic signed [INV_W-1:0] o_inventory_state,
   output logic                    o_inv_valid,
   output logic                    o_long_limit,
   output logic                    o_short_limit,
   output logic                    o_sat
`ifdef INV_TRACKER_STATS_EN
   ,
   output logic [63:0]             o_buy_volume,
   output logic [63:0]             o_sell_volume
`endif
);
   localparam logic signed [INV_W-1:0] LIM_P = INV_W'(POS_LIMIT);
   localparam logic signed [INV_W-1:0] LIM_N = -LIM_P;

   inv_state_t              state;
   logic                    accept;
   logic [QTY_W-1:0]        qty;
   logic signed [INV_W:0]   qty_ext;
   logic signed [INV_W:0]   delta;
   logic                    s1_valid;
   logic signed [INV_W:0]   s1_delta;
   logic signed [INV_W-1:0] sum;
   logic                    ovf;

   // Ready depends only on FSM state and flatten so upstream never sees a valid->ready loop
   assign fill.o_fill_ready = (state == RUN) && !i_flatten;
   assign accept            = fill.i_fill_valid && fill.o_fill_ready;

   assign qty     = QTY_W'(fill.i_fill_qty);
   assign qty_ext = (INV_W+1)'(qty);
   assign delta   = (fill.i_fill_side == SELL) ? -qty_ext : qty_ext;

   sat_add_s #(.W(INV_W)) u_sat_add (
      .a   ({o_inventory_state[INV_W-1], o_inventory_state}),
      .b   (s1_delta),
      .sum (sum),
      .ovf (ovf)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state             <= RUN;
         s1_valid          <= 1'b0;
         s1_delta          <= '0;
         o_inventory_state <= '0;
         o_inv_valid       <= 1'b0;
         o_long_limit      <= 1'b0;
         o_short_limit     <= 1'b0;
         o_sat             <= 1'b0;
      end else begin
         s1_valid    <= accept;
         o_inv_valid <= 1'b0;
         if (accept) begin
            s1_delta <= delta;
         end

         // Stage 2: fold the registered delta into the registered position
         if (s1_valid) begin
            o_inventory_state <= sum;
            o_inv_valid       <= 1'b1;
            o_long_limit      <= (sum >= LIM_P);
            o_short_limit     <= (sum <= LIM_N);
            if (ovf) begin
               o_sat <= 1'b1;
            end
         end

         unique case (state)
            RUN:   if (i_flatten) state <= DRAIN;
            DRAIN: state <= ZERO;
            ZERO: begin
               o_inventory_state <= '0;
               o_sat             <= 1'b0;
               o_long_limit      <= 1'b0;
               o_short_limit     <= 1'b0;
               o_inv_valid       <= 1'b1;
               state             <= HOLD;
            end
            HOLD:  if (!i_flatten) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef INV_TRACKER_STATS_EN
   // Volume counters survive flatten; only reset clears them
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_buy_volume  <= '0;
         o_sell_volume <= '0;
      end else if (accept) begin
         if (fill.i_fill_side == SELL) begin
            o_sell_volume <= o_sell_volume + 64'(qty);
         end else begin
            o_buy_volume  <= o_buy_volume + 64'(qty);
         end
      end
   end
`endif

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed self-checking bench for inventory_tracker: 64-bit default instance plus an 8-bit saturation instance.
module tb_inventory_tracker;
   import hft_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic flat_a, flat_b;

   always #5 clk = ~clk;

   inventory_tracker_if #(.QTY_W(32)) fa ();
   inventory_tracker_if #(.QTY_W(8))  fb ();

   logic signed [63:0] inv_a;
   logic               iv_a, long_a, short_a, sat_a;
   logic signed [7:0]  inv_b;
   logic               iv_b, long_b, short_b, sat_b;
`ifdef INV_TRACKER_STATS_EN
   logic [63:0] buy_a, sell_a, buy_b, sell_b;
`endif

   inventory_tracker #(.QTY_W(32), .INV_W(64), .POS_LIMIT(10000)) dut_a (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .fill              (fa.slave),
      .i_flatten         (flat_a),
      .o_inventory_state (inv_a),
      .o_inv_valid       (iv_a),
      .o_long_limit      (long_a),
      .o_short_limit     (short_a),
      .o_sat             (sat_a)
`ifdef INV_TRACKER_STATS_EN
      ,
      .o_buy_volume      (buy_a),
      .o_sell_volume     (sell_a)
`endif
   );

   inventory_tracker #(.QTY_W(8), .INV_W(8), .POS_LIMIT(100)) dut_b (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .fill              (fb.slave),
      .i_flatten         (flat_b),
      .o_inventory_state (inv_b),
      .o_inv_valid       (iv_b),
      .o_long_limit      (long_b),
      .o_short_limit     (short_b),
      .o_sat             (sat_b)
`ifdef INV_TRACKER_STATS_EN
      ,
      .o_buy_volume      (buy_b),
      .o_sell_volume     (sell_b)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input side_t s, input logic [31:0] q);
      fa.i_fill_valid = v;
      fa.i_fill_side  = s;
      fa.i_fill_qty   = q;
   endtask

   task automatic drv_b(input logic v, input side_t s, input logic [7:0] q);
      fb.i_fill_valid = v;
      fb.i_fill_side  = s;
      fb.i_fill_qty   = q;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      flat_a = 1'b0;
      flat_b = 1'b0;
      drv_a(1'b0, BUY, 32'd0);
      drv_b(1'b0, BUY, 8'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("reset_inv", inv_a, 0);
      chk("reset_iv", 64'(iv_a), 0);
      chk("reset_flags", 64'({long_a, short_a, sat_a}), 0);
      chk("reset_ready", 64'(fa.o_fill_ready), 1);

      // Back-to-back fills: buy 150, sell 40, buy 10
      drv_a(1'b1, BUY, 32'd150);  tick();
      drv_a(1'b1, SELL, 32'd40);  tick();
      chk("b2b_150", inv_a, 150);
      chk("b2b_iv0", 64'(iv_a), 1);
      drv_a(1'b1, BUY, 32'd10);   tick();
      chk("b2b_110", inv_a, 110);
      chk("b2b_iv1", 64'(iv_a), 1);
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("b2b_120", inv_a, 120);
      chk("b2b_iv2", 64'(iv_a), 1);
      tick();
      chk("b2b_iv_drop", 64'(iv_a), 0);
      chk("b2b_hold", inv_a, 120);

      // Limit boundaries around 10000
      do_reset();
      drv_a(1'b1, BUY, 32'd9999); tick();
      drv_a(1'b1, BUY, 32'd1);    tick();
      chk("lim_9999", inv_a, 9999);
      chk("lim_long0", 64'(long_a), 0);
      drv_a(1'b1, SELL, 32'd20000); tick();
      chk("lim_10000", inv_a, 10000);
      chk("lim_long1", 64'(long_a), 1);
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("lim_m10000", inv_a, -10000);
      chk("lim_short1", 64'(short_a), 1);
      chk("lim_long_clr", 64'(long_a), 0);
      chk("lim_nosat", 64'(sat_a), 0);

      // Flatten right after a buy of 500
      do_reset();
      drv_a(1'b1, BUY, 32'd500);  tick();
      drv_a(1'b0, BUY, 32'd0);
      flat_a = 1'b1;
      #1;
      chk("fl_ready_low", 64'(fa.o_fill_ready), 0);
      tick();
      chk("fl_500", inv_a, 500);
      chk("fl_iv500", 64'(iv_a), 1);
      tick();
      chk("fl_drain", inv_a, 500);
      chk("fl_drain_iv", 64'(iv_a), 0);
      tick();
      chk("fl_zero", inv_a, 0);
      chk("fl_zero_iv", 64'(iv_a), 1);
      drv_a(1'b1, BUY, 32'd7);
      tick();
      tick();
      chk("fl_hold_ready", 64'(fa.o_fill_ready), 0);
      chk("fl_hold_inv", inv_a, 0);
      chk("fl_hold_iv", 64'(iv_a), 0);
      drv_a(1'b0, BUY, 32'd0);
      flat_a = 1'b0;
      tick();
      chk("fl_run_ready", 64'(fa.o_fill_ready), 1);
      chk("fl_no_hold_fill", inv_a, 0);
      drv_a(1'b1, BUY, 32'd5);    tick();
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("fl_after5", inv_a, 5);

      // Reset with a fill sitting in stage 1
      drv_a(1'b1, BUY, 32'd77);   tick();
      drv_a(1'b0, BUY, 32'd0);
      do_reset();
      #1;
      chk("rst_mid_inv", inv_a, 0);
      chk("rst_mid_iv", 64'(iv_a), 0);
      tick();
      chk("rst_mid_inv2", inv_a, 0);
      chk("rst_mid_iv2", 64'(iv_a), 0);
      drv_a(1'b1, BUY, 32'd33);   tick();
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("rst_mid_33", inv_a, 33);

      // Zero-quantity fill still pulses
      drv_a(1'b1, SELL, 32'd0);   tick();
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("zero_qty_inv", inv_a, 33);
      chk("zero_qty_iv", 64'(iv_a), 1);

      // 8-bit instance: saturation both ways
      drv_b(1'b1, BUY, 8'd100);   tick();
      drv_b(1'b1, BUY, 8'd100);   tick();
      chk("s8_100", 64'(inv_b), 100);
      chk("s8_long", 64'(long_b), 1);
      chk("s8_nosat", 64'(sat_b), 0);
      drv_b(1'b1, SELL, 8'd255);  tick();
      chk("s8_127", 64'(inv_b), 127);
      chk("s8_sat", 64'(sat_b), 1);
      drv_b(1'b1, SELL, 8'd255);  tick();
      chk("s8_m128", 64'(inv_b), -128);
      chk("s8_short", 64'(short_b), 1);
      chk("s8_sat_sticky", 64'(sat_b), 1);
      drv_b(1'b0, BUY, 8'd0);     tick();
      chk("s8_clamp_low", 64'(inv_b), -128);
      flat_b = 1'b1;
      tick(); tick(); tick();
      chk("s8_flat_zero", 64'(inv_b), 0);
      chk("s8_flat_sat_clr", 64'(sat_b), 0);
      chk("s8_flat_short_clr", 64'(short_b), 0);
      flat_b = 1'b0;
      tick();

`ifdef INV_TRACKER_STATS_EN
      do_reset();
      drv_a(1'b1, BUY, 32'd30);   tick();
      drv_a(1'b1, SELL, 32'd12);  tick();
      drv_a(1'b0, BUY, 32'd0);    tick();
      flat_a = 1'b1;
      tick(); tick(); tick(); tick();
      flat_a = 1'b0;
      tick();
      drv_a(1'b1, BUY, 32'd8);    tick();
      drv_a(1'b0, BUY, 32'd0);    tick();
      chk("st_inv", inv_a, 8);
      chk("st_buy", buy_a, 38);
      chk("st_sell", sell_a, 12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/inventory_tracker.md
Name: inventory_tracker

Overview:
- Upstream neighbour of order_quantity.
- Consumes exchange fill events (side, quantity) over a valid/ready handshake and maintains the signed net position.
- Publishes the position as `o_inventory_state`, which drives `order_quantity.inventory_state`.
- Also provides position-limit flags, a sticky saturation flag, and a flatten (zero-position) command for the risk controller.

Parameters:
- QTY_W, 32, width of unsigned fill quantity
- INV_W, 64, width of signed inventory (matches order_quantity input)
- POS_LIMIT, 10000, absolute position threshold for the limit flags (positive, < 2^(INV_W-1))

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_fill_valid  in  1  fill event present
- o_fill_ready  out  1  tracker accepts fill this cycle
- i_fill_side  in  1  0 = buy (+qty), 1 = sell (−qty)
- i_fill_qty  in  QTY_W  unsigned fill size
- i_flatten  in  1  level request to zero the position
- o_inventory_state  out  INV_W  signed net position
- o_inv_valid  out  1  one-cycle pulse when o_inventory_state changes value source (update or flatten)
- o_long_limit  out  1  o_inventory_state >= POS_LIMIT
- o_short_limit  out  1  o_inventory_state <= −POS_LIMIT
- o_sat  out  1  sticky: an update saturated

Behaviour:
- Reset (i_rst_n low at clock edge): state RUN; inventory 0; stage-1 register empty; o_inv_valid, o_long_limit, o_short_limit, o_sat all 0. Reset mid-operation discards any in-flight fill.
- Handshake: a fill is accepted when i_fill_valid && o_fill_ready. o_fill_ready = (state == RUN) && !i_flatten. It is combinational from state and i_flatten only, never from i_fill_valid.
- Pipeline:
  - Stage 1 (cycle N+1 after acceptance at edge N): register signed delta = side ? −qty : +qty, sign-extended to INV_W+1.
  - Stage 2 (edge N+2): inventory <= sat(inventory + delta); o_inv_valid = 1 during cycle N+2.
  - Total latency is 2 cycles. Throughput is one fill per cycle; back-to-back fills accumulate correctly because stage 2 uses the registered inventory.
- Arithmetic:
  - Sum is computed in INV_W+1 bits.
  - If the sum exceeds 2^(INV_W-1)−1, clamp to that maximum; if it is below −2^(INV_W-1), clamp to that minimum.
  - On clamp, set o_sat = 1.
- Limit flags are registered and updated in the same edge as inventory, so they are always consistent with o_inventory_state.
- State machine:
  - RUN: accept fills. When i_flatten = 1, go to DRAIN. A fill accepted in the same cycle flatten rises is impossible, because ready is already low.
  - DRAIN: ready = 0. Wait one cycle for stage 1 to retire into inventory, then go to ZERO.
  - ZERO: inventory <= 0; o_sat <= 0; limit flags <= 0; o_inv_valid pulses next cycle. Then go to HOLD.
  - HOLD: ready = 0, inventory held at 0. Return to RUN when i_flatten = 0.
- If i_flatten drops during DRAIN, the sequence still completes through ZERO before returning to RUN.
- A fill with qty = 0 is accepted and produces an o_inv_valid pulse with an unchanged value.

Optional Feature:
- Macro: INV_TRACKER_STATS_EN.
- When defined:
  - Adds ports o_buy_volume and o_sell_volume, each out, 64 bits, unsigned.
  - Each accumulates accepted quantities per side. Updated at stage 1. Wrap at 2^64. Cleared only by reset, not by flatten.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hft_pkg holds:
  - typedef side_t (BUY = 0, SELL = 1)
  - enum inv_state_t {RUN, DRAIN, ZERO, HOLD}
  - localparam INV_W_DEFAULT = 64
- One sub-module, sat_add_s:
  - Parameterised signed saturating adder, combinational.
  - Outputs the sum and an overflow flag.
  - Reused later by the order-sizing path.

Test Plan:
- Reset then fills buy 150, sell 40, buy 10 on consecutive cycles → o_inventory_state = 150, 110, 120 at accept+2; o_inv_valid high three consecutive cycles.
- Buy 9999 then buy 1 (POS_LIMIT = 10000) → o_long_limit 0 then 1, asserted in the same cycle the inventory reads 10000; then sell 20000 → −10000 and o_short_limit = 1.
- INV_W = 8, QTY_W = 8: buy 100 then buy 100 → 127 and o_sat = 1; sell 255 → −128.
- Buy 500 accepted, then i_flatten asserted the next cycle → ready low; inventory reaches 500, then 0 two cycles later; o_inv_valid pulses; HOLD persists until i_flatten drops; then a buy of 5 gives 5.
- Assert i_rst_n = 0 for one edge with a fill in stage 1 → inventory 0, no o_inv_valid; the next fill gives exactly its own quantity.
- With INV_TRACKER_STATS_EN: buy 30, sell 12, flatten, buy 8 → o_buy_volume = 38, o_sell_volume = 12.
